// File: rtl/calendar_uart_tx.sv
// calendar_uart_tx: snapshots the BCD calendar digits on send and transmits "DD/MM HH:MM:SS.dc\r\n" over 8N1 UART
module calendar_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [3:0] centesimas,
    input  logic [3:0] decimas,
    input  logic [3:0] unidadesSegundo,
    input  logic [2:0] decenasSegundo,
    input  logic [3:0] unidadesMinuto,
    input  logic [3:0] decenasMinuto,
    input  logic [3:0] unidadesHora,
    input  logic [1:0] decenasHora,
    input  logic [3:0] unidadesDia,
    input  logic [2:0] decenasDia,
    input  logic [3:0] unidadesMes,
    input  logic       decenasMes,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    state_t state;
    logic [4:0] charIdx;
    logic [2:0] bitIdx;
    logic [15:0] baudCnt;
    logic [11:0][3:0] dig;
    logic [7:0] curChar;
    logic bitEnd;

    function automatic logic [7:0] asc(input logic [3:0] v);
        return v > 4'd9 ? 8'h3F : {4'h3, v};
    endfunction

    assign bitEnd = baudCnt == LAST_CNT;

    // dig[] holds the digits in the order they appear on the line
    always_comb begin
        curChar = 8'h0A;
        case (charIdx)
            5'd0:  curChar = asc(dig[0]);
            5'd1:  curChar = asc(dig[1]);
            5'd2:  curChar = 8'h2F;
            5'd3:  curChar = asc(dig[2]);
            5'd4:  curChar = asc(dig[3]);
            5'd5:  curChar = 8'h20;
            5'd6:  curChar = asc(dig[4]);
            5'd7:  curChar = asc(dig[5]);
            5'd8:  curChar = 8'h3A;
            5'd9:  curChar = asc(dig[6]);
            5'd10: curChar = asc(dig[7]);
            5'd11: curChar = 8'h3A;
            5'd12: curChar = asc(dig[8]);
            5'd13: curChar = asc(dig[9]);
            5'd14: curChar = 8'h2E;
            5'd15: curChar = asc(dig[10]);
            5'd16: curChar = asc(dig[11]);
            5'd17: curChar = 8'h0D;
            default: curChar = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            charIdx <= '0;
            bitIdx  <= '0;
            baudCnt <= '0;
        end else begin
            done    <= 1'b0;
            baudCnt <= (state == IDLE || bitEnd) ? '0 : baudCnt + 16'd1;
            case (state)
                IDLE: if (send) begin
                    dig <= {centesimas, decimas, unidadesSegundo, {1'b0, decenasSegundo},
                            unidadesMinuto, decenasMinuto, unidadesHora, {2'b0, decenasHora},
                            unidadesMes, {3'b0, decenasMes}, unidadesDia, {1'b0, decenasDia}};
                    busy    <= 1'b1;
                    charIdx <= '0;
                    state   <= START;
                    tx      <= 1'b0;
                end
                START: if (bitEnd) begin
                    state  <= DATA;
                    bitIdx <= '0;
                    tx     <= curChar[0];
                end
                DATA: if (bitEnd) begin
                    if (bitIdx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        bitIdx <= bitIdx + 3'd1;
                        tx     <= curChar[bitIdx + 3'd1];
                    end
                end
                STOP: if (bitEnd) begin
                    if (charIdx == 5'd18) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        charIdx <= charIdx + 5'd1;
                        state   <= START;
                        tx      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calendar_uart_tx.sv
// tb_calendar_uart_tx: random and directed lines, UART-decoding monitor against a text-template reference model
module tb_calendar_uart_tx;
    localparam int CPB = 4;
    logic clk = 0, rst = 1, send = 0;
    logic [3:0] centesimas = 0, decimas = 0, unidadesSegundo = 0, unidadesMinuto = 0;
    logic [3:0] decenasMinuto = 0, unidadesHora = 0, unidadesDia = 0, unidadesMes = 0;
    logic [2:0] decenasSegundo = 0, decenasDia = 0;
    logic [1:0] decenasHora = 0;
    logic decenasMes = 0;
    logic tx, busy, done;
    int checks = 0, fails = 0, cyc = 0, lineStart = 0, byteInLine = 0;
    int dg[12];
    logic [7:0] expQ[$];
    int doneQ[$];
    logic aborted;

    calendar_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .send(send),
        .centesimas(centesimas), .decimas(decimas),
        .unidadesSegundo(unidadesSegundo), .decenasSegundo(decenasSegundo),
        .unidadesMinuto(unidadesMinuto), .decenasMinuto(decenasMinuto),
        .unidadesHora(unidadesHora), .decenasHora(decenasHora),
        .unidadesDia(unidadesDia), .decenasDia(decenasDia),
        .unidadesMes(unidadesMes), .decenasMes(decenasMes),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic waitNeg(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rst) aborted = 1;
        end
    endtask

    task automatic applyDigits();
        decenasDia = 3'(dg[0]);      unidadesDia = 4'(dg[1]);
        decenasMes = 1'(dg[2]);      unidadesMes = 4'(dg[3]);
        decenasHora = 2'(dg[4]);     unidadesHora = 4'(dg[5]);
        decenasMinuto = 4'(dg[6]);   unidadesMinuto = 4'(dg[7]);
        decenasSegundo = 3'(dg[8]);  unidadesSegundo = 4'(dg[9]);
        decimas = 4'(dg[10]);        centesimas = 4'(dg[11]);
    endtask

    // Reference: fill the text template, each '#' takes the next digit in reading order
    task automatic pushLine();
        string tpl = "##/## ##:##:##.##";
        int n = 0;
        for (int i = 0; i < tpl.len(); i++)
            if (tpl[i] == "#") begin
                expQ.push_back(dg[n] < 10 ? 8'(8'h30 + dg[n]) : 8'h3F);
                n++;
            end else expQ.push_back(tpl[i]);
        expQ.push_back(8'h0D);
        expQ.push_back(8'h0A);
        doneQ.push_back(1);
    endtask

    task automatic randomDigits();
        dg[0] = $urandom_range(0, 7);  dg[1] = $urandom_range(0, 15);
        dg[2] = $urandom_range(0, 1);  dg[3] = $urandom_range(0, 15);
        dg[4] = $urandom_range(0, 3);  dg[5] = $urandom_range(0, 15);
        dg[6] = $urandom_range(0, 15); dg[7] = $urandom_range(0, 15);
        dg[8] = $urandom_range(0, 7);  dg[9] = $urandom_range(0, 15);
        dg[10] = $urandom_range(0, 15); dg[11] = $urandom_range(0, 15);
    endtask

    task automatic basicDigits();
        dg = '{2, 7, 1, 1, 2, 3, 5, 9, 5, 9, 9, 9};
    endtask

    task automatic issue(input bit zeroAfter);
        applyDigits();
        pushLine();
        send = 1;
        @(negedge clk);
        send = 0;
        if (zeroAfter) begin
            {centesimas, decimas, unidadesSegundo, unidadesMinuto} = '0;
            {decenasMinuto, unidadesHora, unidadesDia, unidadesMes} = '0;
            {decenasSegundo, decenasDia, decenasHora, decenasMes} = '0;
        end
    endtask

    task automatic waitDone();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 1000);
        if (done !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL done timeout: no done within %0d cycles", n);
        end
    endtask

    // Monitor: decode UART frames, sampling mid-bit on falling clock edges
    initial begin
        logic [7:0] b;
        logic stopBit;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !rst) begin
                aborted = 0;
                if (byteInLine == 0) lineStart = cyc;
                chk("busy during frame", busy, 1);
                waitNeg(2);
                for (int k = 0; k < 8; k++) begin
                    waitNeg(4);
                    b[k] = tx;
                end
                waitNeg(4);
                stopBit = tx;
                if (aborted) byteInLine = 0;
                else begin
                    chk("stop bit", stopBit, 1);
                    if (expQ.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected byte: got %02h, none expected", b);
                    end else chk("byte", b, expQ.pop_front());
                    byteInLine = byteInLine == 18 ? 0 : byteInLine + 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (doneQ.size() == 0) chk("done while none expected", done, 0);
                else begin
                    void'(doneQ.pop_front());
                    chk("line length", cyc - lineStart, 190 * CPB);
                    chk("busy at done", busy, 0);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle tx", tx, 1);
            chk("idle busy", busy, 0);
            chk("idle done", done, 0);
        end
        basicDigits();
        issue(0);
        waitDone();
        basicDigits();
        issue(1);
        waitDone();
        @(negedge clk);
        randomDigits();
        issue(0);
        repeat (100) @(negedge clk);
        send = 1;
        @(negedge clk);
        send = 0;
        repeat (300) @(negedge clk);
        send = 1;
        @(negedge clk);
        send = 0;
        waitDone();
        repeat (60) @(negedge clk);
        chk("tx after ignored sends", tx, 1);
        chk("busy after ignored sends", busy, 0);
        randomDigits();
        applyDigits();
        pushLine();
        send = 1;
        waitDone();
        randomDigits();
        applyDigits();
        pushLine();
        @(negedge clk);
        chk("b2b start bit", tx, 0);
        chk("b2b busy", busy, 1);
        send = 0;
        waitDone();
        @(negedge clk);
        basicDigits();
        dg[5] = 12;
        issue(0);
        waitDone();
        @(negedge clk);
        randomDigits();
        issue(0);
        repeat (211) @(negedge clk);
        rst = 1;
        expQ.delete();
        doneQ.delete();
        @(negedge clk);
        chk("rst mid tx", tx, 1);
        chk("rst mid busy", busy, 0);
        chk("rst mid done", done, 0);
        @(negedge clk);
        rst = 0;
        repeat (60) @(negedge clk);
        chk("tx after abort", tx, 1);
        basicDigits();
        issue(0);
        waitDone();
        for (int i = 0; i < 6; i++) begin
            randomDigits();
            issue(0);
            waitDone();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        repeat (100) @(negedge clk);
        chk("leftover bytes", expQ.size(), 0);
        chk("leftover done", doneQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/calendar_uart_tx.md
Name: calendar_uart_tx

Overview:
- Reads the BCD calendar/time digit registers of the clock datapath and transmits them as one ASCII text line over an 8N1 UART.
- On a `send` request the block captures all digits in the same cycle, so the line cannot tear while the counters roll over. It then serializes the line `DD/MM HH:MM:SS.dc` followed by CR LF.
- Sits beside the digit counters as their read-out end; drives the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- send  input  1  request a line transmit; sampled every cycle
- centesimas  input  4  BCD hundredths digit
- decimas  input  4  BCD tenths digit
- unidadesSegundo  input  4  BCD seconds units
- decenasSegundo  input  3  BCD seconds tens
- unidadesMinuto  input  4  BCD minutes units
- decenasMinuto  input  4  BCD minutes tens
- unidadesHora  input  4  BCD hours units
- decenasHora  input  2  BCD hours tens
- unidadesDia  input  4  BCD day units
- decenasDia  input  3  BCD day tens
- unidadesMes  input  4  BCD month units
- decenasMes  input  1  BCD month tens
- tx  output  1  UART serial out; idles high
- busy  output  1  high while a line is in progress
- done  output  1  one-cycle pulse when the last stop bit of LF completes

Behaviour:
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, char index=0, bit index=0, baud counter=0.
- rst has priority over all other inputs in every state. If rst is asserted mid-frame, tx=1 at the next edge and the line is abandoned with no done pulse.
- Accept rule: send is accepted on a rising clk when busy==0, including the cycle where done==1 (back-to-back lines allowed). send while busy==1 is ignored, not queued.
- On accept:
  - Capture all 12 digit inputs into internal registers; zero-extend each to 4 bits.
  - Set busy=1 and char index=0.
  - Enter START; tx goes 0 at that same edge, so latency is 1 cycle from the send sample.
- Character sequence, 19 chars, index 0..18:
  - Date: decenasDia, unidadesDia, '/', decenasMes, unidadesMes, ' '.
  - Time: decenasHora, unidadesHora, ':', decenasMinuto, unidadesMinuto, ':', decenasSegundo, unidadesSegundo, '.'.
  - Fraction and terminator: decimas, centesimas, 0x0D, 0x0A.
- Digit encoding: value 0..9 -> 0x30+value; value 10..15 -> '?' (0x3F).
- Digits are sent exactly as stored. Month stays 0-based and day is not adjusted; no calendar conversion.
- FSM states:
  - IDLE: tx=1; waits for accept.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: tx=char[bit index], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If char index<18: increment char index and go to START; no idle gap between characters.
    - If char index==18: go to IDLE, set busy=0, done=1 for exactly one cycle.
- Timing:
  - Baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 on every bit boundary.
  - Each character is 10*CLKS_PER_BIT cycles.
  - A full line is 190*CLKS_PER_BIT cycles, measured from the first tx=0 to the done pulse inclusive.
- Input changes after accept have no effect on the line in progress.

Test Plan:
- Reset and idle, CLKS_PER_BIT=4: assert rst 3 cycles, then hold send=0 -> tx=1, busy=0, done=0 on every cycle.
- Basic line, CLKS_PER_BIT=4:
  - Stimulus: digits for day 2/7, month 1/1, 2 3:5 9:5 9.9 9; pulse send 1 cycle.
  - Required: UART-decoded bytes "27/11 23:59:59.99\r\n"; done rises exactly 760 cycles after the first tx=0.
- Capture before rollover: change all digit inputs to 0 one cycle after send -> transmitted line still "27/11 23:59:59.99\r\n".
- Ignored send and back-to-back:
  - send pulses mid-line -> exactly one line is sent.
  - send held high continuously -> second line's start bit begins on the edge after done, with no idle bit.
- Illegal digit: unidadesHora=4'hC -> eighth character is 0x3F ('?'); all other characters are unaffected.
- Reset mid-frame: assert rst during DATA of character 5 -> tx=1 at the next edge, busy=0, no done pulse. A fresh send then restarts at character 0.
